dmem_responder: RTL and testbench



---
 rtl/dmem_responder_if.sv | 34 +++
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 tb/tb_dmem_responder.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/store/response bundle between the memory functional unit (master) and dmem_responder (slave).
// A load transfers on a rising clk edge where load_req_valid && load_req_ready && !flush; the master holds
// its fields stable while valid is high. store_valid is a one-cycle write strobe with no ready.
// resp_valid is a one-cycle pulse that has no back-pressure.
interface dmem_responder_if;
  logic        load_req_valid;
  logic        load_req_ready;
  logic [31:0] load_addr;
  logic [2:0]  load_funct3;
  logic [6:0]  load_pd;
  logic [4:0]  load_rob;
  logic        store_valid;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic [2:0]  store_funct3;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [6:0]  resp_pd;
  logic [4:0]  resp_rob;
  logic        resp_err;

  modport master (
    output load_req_valid, load_addr, load_funct3, load_pd, load_rob,
    output store_valid, store_addr, store_data, store_funct3, flush,
    input  load_req_ready, resp_valid, resp_data, resp_pd, resp_rob, resp_err
  );

  modport slave (
    input  load_req_valid, load_addr, load_funct3, load_pd, load_rob,
    input  store_valid, store_addr, store_data, store_funct3, flush,
    output load_req_ready, resp_valid, resp_data, resp_pd, resp_rob, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load with fixed latency, committed byte/half/word stores, flush kill.
// Optional DMEM_ALIGN_CHECK_EN: misaligned loads return resp_err=1/data 0 and misaligned stores are dropped.
module dmem_responder #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int LOAD_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus,
  output logic [1:0]       state_dbg
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LOAD_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          accept, ready_c, resp_fire;

  logic [AW+1:0] lat_addr_q;
  logic [2:0]    lat_f3_q;
  logic [6:0]    lat_pd_q;
  logic [4:0]    lat_rob_q;

  logic [31:0]   hold_data_q;
  logic [6:0]    hold_pd_q;
  logic [4:0]    hold_rob_q;
  logic          hold_err_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic          ld_mis;
  logic [31:0]   ld_data;

  logic [AW-1:0] st_idx;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;

  // Address bits above the array are ignored so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.load_addr[31:AW+2], bus.store_addr[31:AW+2]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    ready_c   = 1'b0;
    resp_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.load_req_valid && !bus.flush) begin
          accept  = 1'b1;
          cnt_d   = LAT_M1;
          state_d = (LOAD_LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (bus.flush)          state_d = S_IDLE;
        else if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        resp_fire = !bus.flush;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      lat_addr_q  <= '0;
      lat_f3_q    <= 3'd0;
      lat_pd_q    <= 7'd0;
      lat_rob_q   <= 5'd0;
      hold_data_q <= 32'd0;
      hold_pd_q   <= 7'd0;
      hold_rob_q  <= 5'd0;
      hold_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        lat_addr_q <= bus.load_addr[AW+1:0];
        lat_f3_q   <= bus.load_funct3;
        lat_pd_q   <= bus.load_pd;
        lat_rob_q  <= bus.load_rob;
      end
      if (resp_fire) begin
        hold_data_q <= ld_data;
        hold_pd_q   <= lat_pd_q;
        hold_rob_q  <= lat_rob_q;
        hold_err_q  <= ld_mis;
      end
    end
  end

  // Array read happens in the RESP cycle itself, so stores up to the edge entering RESP are seen.
  assign rd_word = mem[lat_addr_q[AW+1:2]];

  always_comb begin
    ld_data = '0;
    ld_mis  = 1'b0;
    rd_byte = rd_word[{lat_addr_q[1:0], 3'b000} +: 8];
    rd_half = rd_word[{lat_addr_q[1], 4'b0000} +: 16];
    case (lat_f3_q)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ld_data = {24'd0, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  ld_data = {16'd0, rd_half};
      default: ld_data = rd_word;
    endcase
`ifdef DMEM_ALIGN_CHECK_EN
    case (lat_f3_q)
      3'b000, 3'b100: ld_mis = 1'b0;
      3'b001, 3'b101: ld_mis = lat_addr_q[0];
      default:        ld_mis = |lat_addr_q[1:0];
    endcase
    if (ld_mis) ld_data = '0;
`endif
  end

  always_comb begin
    st_idx   = bus.store_addr[AW+1:2];
    st_be    = 4'b0000;
    st_wdata = bus.store_data;
    case (bus.store_funct3)
      3'b000: begin
        st_be    = 4'b0001 << bus.store_addr[1:0];
        st_wdata = {4{bus.store_data[7:0]}};
      end
      3'b001: begin
        st_be    = bus.store_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{bus.store_data[15:0]}};
      end
      default: st_be = 4'b1111;
    endcase
`ifdef DMEM_ALIGN_CHECK_EN
    if ((bus.store_funct3 == 3'b001 && bus.store_addr[0]) ||
        (bus.store_funct3 != 3'b000 && bus.store_funct3 != 3'b001 && bus.store_addr[1:0] != 2'b00))
      st_be = 4'b0000;
`endif
  end

  // Committed stores are never stalled and ignore flush and FSM state.
  always_ff @(posedge clk) begin
    if (bus.store_valid) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[st_idx][8*i +: 8] <= st_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    bus.load_req_ready = ready_c;
    bus.resp_valid     = resp_fire;
    bus.resp_data      = resp_fire ? ld_data   : hold_data_q;
    bus.resp_pd        = resp_fire ? lat_pd_q  : hold_pd_q;
    bus.resp_rob       = resp_fire ? lat_rob_q : hold_rob_q;
    bus.resp_err       = resp_fire ? ld_mis    : hold_err_q;
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written corner sequences,
// and a randomized phase scored against a byte-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int AW    = 10;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LOAD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  ref_mem [0:4*DEPTH-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: memory as a flat byte array, loads/stores by byte address.
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3, output logic err);
    int ba, hb, wb;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w, r;
    ba = int'(a[AW+1:0]);
    hb = ba - (ba % 2);
    wb = ba - (ba % 4);
    b  = ref_mem[ba];
    h  = {ref_mem[hb+1], ref_mem[hb]};
    w  = {ref_mem[wb+3], ref_mem[wb+2], ref_mem[wb+1], ref_mem[wb]};
    err = 1'b0;
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd4:    r = {24'd0, b};
      3'd1:    begin r = {{16{h[15]}}, h}; err = ALIGN_CHK && (ba % 2 != 0); end
      3'd5:    begin r = {16'd0, h};       err = ALIGN_CHK && (ba % 2 != 0); end
      default: begin r = w;                err = ALIGN_CHK && (ba % 4 != 0); end
    endcase
    if (err) r = 32'd0;
    return r;
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    int ba, hb, wb;
    ba = int'(a[AW+1:0]);
    hb = ba - (ba % 2);
    wb = ba - (ba % 4);
    case (f3)
      3'd0: ref_mem[ba] = d[7:0];
      3'd1: if (!(ALIGN_CHK && ba % 2 != 0)) begin
        ref_mem[hb] = d[7:0]; ref_mem[hb+1] = d[15:8];
      end
      default: if (!(ALIGN_CHK && ba % 4 != 0)) begin
        for (int k = 0; k < 4; k++) ref_mem[wb+k] = d[8*k +: 8];
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.load_req_valid = 1'b0; bus.load_addr = '0; bus.load_funct3 = '0;
    bus.load_pd = '0; bus.load_rob = '0;
    bus.store_valid = 1'b0; bus.store_addr = '0; bus.store_data = '0; bus.store_funct3 = '0;
    bus.flush = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    bus.store_valid = 1'b1; bus.store_addr = a; bus.store_data = d; bus.store_funct3 = f3;
    step();
    bus.store_valid = 1'b0;
    model_store(a, d, f3);
  endtask

  task automatic set_load(input logic [31:0] a, input logic [2:0] f3, input logic [6:0] pd, input logic [4:0] rob);
    bus.load_req_valid = 1'b1; bus.load_addr = a; bus.load_funct3 = f3;
    bus.load_pd = pd; bus.load_rob = rob;
  endtask

  task automatic run_load(input logic [31:0] a, input logic [2:0] f3, input logic [6:0] pd, input logic [4:0] rob,
                          output logic [31:0] d, output logic e, output logic [6:0] rpd,
                          output logic [4:0] rrob, output int lat);
    bit acc = 1'b0;
    d = '0; e = 1'b0; rpd = '0; rrob = '0; lat = -1;
    set_load(a, f3, pd, rob);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.load_req_ready) begin acc = 1'b1; break; end
      step();
    end
    step();
    bus.load_req_valid = 1'b0;
    if (acc) begin
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (bus.resp_valid) begin
          d = bus.resp_data; e = bus.resp_err; rpd = bus.resp_pd; rrob = bus.resp_rob; lat = i;
          break;
        end
        step();
      end
      step();
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [6:0]  pd;
    logic [4:0]  rob;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  // ---------------- test body ----------------
  initial begin : main
    logic [31:0] d, md;
    logic        e, me;
    logic [6:0]  rpd, last_pd;
    logic [4:0]  rrob;
    logic [31:0] last_data;
    logic [11:0] tag;
    int          lat, cyc, resp_c;
    bit          pending, acc;
    logic [31:0] pend_addr;
    logic [2:0]  pend_f3;
    logic        lv, sv, fl;
    logic [31:0] la, sa, sd;
    logic [2:0]  lf, sf;
    logic [2:0]  f3_pool[7];

    f3_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};

    vecs.push_back('{32'h10,       3'd2, 7'd5,  5'd3,  32'hDEADBEEF, 1'b0});
    vecs.push_back('{32'h13,       3'd0, 7'd6,  5'd4,  32'hFFFFFFDE, 1'b0});
    vecs.push_back('{32'h13,       3'd4, 7'd7,  5'd5,  32'h000000DE, 1'b0});
    vecs.push_back('{32'h12,       3'd1, 7'd8,  5'd6,  32'hFFFFDEAD, 1'b0});
    vecs.push_back('{32'h10,       3'd5, 7'd9,  5'd7,  32'h0000BEEF, 1'b0});
    vecs.push_back('{32'h10,       3'd0, 7'd10, 5'd8,  32'hFFFFFFEF, 1'b0});
    vecs.push_back('{32'h11,       3'd4, 7'd11, 5'd9,  32'h000000BE, 1'b0});
    vecs.push_back('{32'h12,       3'd0, 7'd12, 5'd10, 32'hFFFFFFAD, 1'b0});
    vecs.push_back('{32'h10,       3'd1, 7'd13, 5'd11, 32'hFFFFBEEF, 1'b0});
    vecs.push_back('{32'h12,       3'd5, 7'd14, 5'd12, 32'h0000DEAD, 1'b0});
    vecs.push_back('{32'h10,       3'd3, 7'd15, 5'd13, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{32'h10,       3'd7, 7'd16, 5'd14, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{32'h1010,     3'd2, 7'd17, 5'd15, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{32'h80000010, 3'd2, 7'd127,5'd31, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{32'h12,       3'd2, 7'd18, 5'd16, ALIGN_CHK ? 32'h0 : 32'hDEADBEEF, ALIGN_CHK});
    vecs.push_back('{32'h11,       3'd1, 7'd19, 5'd17, ALIGN_CHK ? 32'h0 : 32'hFFFFBEEF, ALIGN_CHK});
    vecs.push_back('{32'h13,       3'd5, 7'd20, 5'd18, ALIGN_CHK ? 32'h0 : 32'h0000DEAD, ALIGN_CHK});

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.load_req_ready), 32'd1);
    check("rst_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_data",  bus.resp_data, 32'd0);
    check("rst_pd",    32'(bus.resp_pd), 32'd0);
    check("rst_rob",   32'(bus.resp_rob), 32'd0);
    check("rst_err",   32'(bus.resp_err), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    step();

    // Vector table over the word at 0x10.
    do_store(32'h10, 32'hDEADBEEF, 3'd2);
    foreach (vecs[i]) begin
      run_load(vecs[i].addr, vecs[i].f3, vecs[i].pd, vecs[i].rob, d, e, rpd, rrob, lat);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_pd", i), 32'(rpd), 32'(vecs[i].pd));
      check($sformatf("vec%0d_rob", i), 32'(rrob), 32'(vecs[i].rob));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(LAT));
    end

    // Sub-word stores.
    do_store(32'h11, 32'h00000055, 3'd0);
    run_load(32'h10, 3'd2, 7'd1, 5'd1, d, e, rpd, rrob, lat);
    check("sb_merge", d, 32'hDEAD55EF);
    do_store(32'h12, 32'hA5A51234, 3'd1);
    run_load(32'h10, 3'd2, 7'd1, 5'd1, d, e, rpd, rrob, lat);
    check("sh_merge", d, 32'h123455EF);
    do_store(32'h11, 32'h0000FFFF, 3'd1);
    run_load(32'h10, 3'd2, 7'd1, 5'd1, d, e, rpd, rrob, lat);
    check("sh_misaligned", d, ALIGN_CHK ? 32'h123455EF : 32'h1234FFFF);
    do_store(32'h20, 32'h00000000, 3'd2);
    do_store(32'h22, 32'h11111111, 3'd2);
    run_load(32'h20, 3'd2, 7'd2, 5'd2, d, e, rpd, rrob, lat);
    check("sw_misaligned", d, ALIGN_CHK ? 32'h00000000 : 32'h11111111);
    last_pd = rpd;
    last_data = d;

    // Flush during WAIT kills the load; a new load is taken two cycles after accept.
    set_load(32'h10, 3'd2, 7'd9, 5'd9);
    @(negedge clk); check("fl_acc_ready", 32'(bus.load_req_ready), 32'd1);
    step(); bus.load_req_valid = 1'b0; bus.flush = 1'b1;
    @(negedge clk);
    check("fl_wait_valid", 32'(bus.resp_valid), 32'd0);
    check("fl_wait_ready", 32'(bus.load_req_ready), 32'd0);
    step(); bus.flush = 1'b0; set_load(32'h20, 3'd2, 7'd10, 5'd11);
    @(negedge clk);
    check("fl_t2_ready", 32'(bus.load_req_ready), 32'd1);
    check("fl_t2_valid", 32'(bus.resp_valid), 32'd0);
    step(); bus.load_req_valid = 1'b0;
    @(negedge clk);
    check("fl_t3_valid", 32'(bus.resp_valid), 32'd0);
    check("fl_hold_pd", 32'(bus.resp_pd), 32'(last_pd));
    check("fl_hold_data", bus.resp_data, last_data);
    step();
    @(negedge clk);
    md = model_load(32'h20, 3'd2, me);
    check("fl_t4_valid", 32'(bus.resp_valid), 32'd1);
    check("fl_t4_data", bus.resp_data, md);
    check("fl_t4_pd", 32'(bus.resp_pd), 32'd10);
    check("fl_t4_rob", 32'(bus.resp_rob), 32'd11);
    last_data = md;
    step();

    // Flush in the RESP cycle suppresses the pulse and leaves held outputs alone.
    set_load(32'h10, 3'd2, 7'd12, 5'd13);
    step(); bus.load_req_valid = 1'b0;
    step(); bus.flush = 1'b1;
    @(negedge clk);
    check("flr_valid", 32'(bus.resp_valid), 32'd0);
    check("flr_hold_pd", 32'(bus.resp_pd), 32'd10);
    check("flr_hold_data", bus.resp_data, last_data);
    step(); bus.flush = 1'b0;
    @(negedge clk);
    check("flr_ready", 32'(bus.load_req_ready), 32'd1);
    check("flr_after_valid", 32'(bus.resp_valid), 32'd0);
    step();

    // Store during WAIT is visible; store in the RESP cycle is not.
    set_load(32'h20, 3'd2, 7'd20, 5'd21);
    step(); bus.load_req_valid = 1'b0;
    bus.store_valid = 1'b1; bus.store_addr = 32'h20; bus.store_data = 32'h12345678; bus.store_funct3 = 3'd2;
    step();
    bus.store_data = 32'hCAFEF00D;
    @(negedge clk);
    check("stw_valid", 32'(bus.resp_valid), 32'd1);
    check("stw_data", bus.resp_data, 32'h12345678);
    step(); bus.store_valid = 1'b0;
    model_store(32'h20, 32'h12345678, 3'd2);
    model_store(32'h20, 32'hCAFEF00D, 3'd2);
    run_load(32'h20, 3'd2, 7'd3, 5'd3, d, e, rpd, rrob, lat);
    check("str_later_data", d, 32'hCAFEF00D);

    // Back-to-back requests with valid held high.
    set_load(32'h10, 3'd2, 7'd30, 5'd1);
    for (int k = 0; k < 3 * (LAT + 1); k++) begin
      @(negedge clk);
      check($sformatf("b2b_ready%0d", k), 32'(bus.load_req_ready), 32'(k % (LAT + 1) == 0));
      check($sformatf("b2b_valid%0d", k), 32'(bus.resp_valid), 32'(k % (LAT + 1) == LAT));
      step();
    end
    bus.load_req_valid = 1'b0;
    repeat (LAT + 2) step();

    // Request presented with flush in IDLE is ignored.
    set_load(32'h10, 3'd2, 7'd40, 5'd2); bus.flush = 1'b1;
    step(); idle_inputs();
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      check($sformatf("idlefl_valid%0d", k), 32'(bus.resp_valid), 32'd0);
      check($sformatf("idlefl_ready%0d", k), 32'(bus.load_req_ready), 32'd1);
      step();
    end

    // Randomized phase against the byte-array model.
    for (int w = 0; w < 16; w++) do_store(32'(w * 4), $urandom, 3'd2);
    pending = 1'b0; resp_c = 0; pend_addr = '0; pend_f3 = '0;
    for (cyc = 0; cyc < 500; cyc++) begin
      lv = ($urandom_range(0, 1) == 1) && (cyc < 490);
      sv = ($urandom_range(0, 2) == 0) && (cyc < 490);
      fl = ($urandom_range(0, 9) == 0) && (cyc < 490);
      la = ($urandom << (AW + 2)) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      sa = ($urandom << (AW + 2)) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      lf = f3_pool[$urandom_range(0, 6)];
      sf = 3'($urandom_range(0, 3));
      sd = $urandom;
      bus.load_req_valid = lv; bus.load_addr = la; bus.load_funct3 = lf;
      bus.load_pd = 7'($urandom); bus.load_rob = 5'($urandom);
      bus.store_valid = sv; bus.store_addr = sa; bus.store_data = sd; bus.store_funct3 = sf;
      bus.flush = fl;
      @(negedge clk);
      check("rnd_ready", 32'(bus.load_req_ready), 32'(!pending));
      check("rnd_valid", 32'(bus.resp_valid), 32'(pending && cyc == resp_c && !fl));
      acc = !pending && lv && !fl;
      if (pending && fl) begin
        void'(exp_q.pop_back());
        pending = 1'b0;
      end else if (pending && cyc == resp_c) begin
        tag = exp_q.pop_front();
        md = model_load(pend_addr, pend_f3, me);
        check("rnd_data", bus.resp_data, md);
        check("rnd_err", 32'(bus.resp_err), 32'(me));
        check("rnd_pd", 32'(bus.resp_pd), 32'(tag[11:5]));
        check("rnd_rob", 32'(bus.resp_rob), 32'(tag[4:0]));
        pending = 1'b0;
      end
      if (acc) begin
        pending = 1'b1; resp_c = cyc + LAT; pend_addr = la; pend_f3 = lf;
        exp_q.push_back({bus.load_pd, bus.load_rob});
      end
      if (sv) model_store(sa, sd, sf);
      step();
    end
    idle_inputs();
    check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a load aborts it.
    set_load(32'h10, 3'd2, 7'd50, 5'd5);
    step(); bus.load_req_valid = 1'b0;
    reset = 1'b1; #1;
    check("midrst_valid", 32'(bus.resp_valid), 32'd0);
    check("midrst_ready", 32'(bus.load_req_ready), 32'd1);
    check("midrst_data", bus.resp_data, 32'd0);
    check("midrst_pd", 32'(bus.resp_pd), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      step(); @(negedge clk);
      check($sformatf("midrst_after%0d", k), 32'(bus.resp_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
